// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One op in flight; the response is held until the consumer takes it.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [4:0]        req0_ctrl_i,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [4:0]        req1_ctrl_i,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  output logic [4:0]        alu_ctrl_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_branch_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_taken_o,
  output logic              rsp_err_o,
  output logic [15:0]       op_count_o
);

  // state | meaning
  // IDLE  | no op in flight, accepting requests
  // EXEC  | latched op driven onto the ALU, result captured at the edge
  // RESP  | response held; accepts a new op when it is taken
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e              state_q, state_d;
  logic                prio_q, prio_d;
  logic [4:0]          ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, data_q, data_d;
  logic                id_q, id_d, taken_q, taken_d, err_q, err_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                accept_win, grant0, grant1;
  logic [4:0]          sel_ctrl;

  function automatic logic is_legal(input logic [4:0] c);
    return (c <= 5'd8) || (c == 5'd13) || (c == 5'd16) || (c == 5'd17) ||
           ((c >= 5'd20) && (c <= 5'd23)) || (c == 5'd31);
  endfunction

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    ctrl_d     = ctrl_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    data_d     = data_q;
    taken_d    = taken_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    alu_ctrl_o = '0;
    alu_a_o    = '0;
    alu_b_o    = '0;
    sel_ctrl   = '0;

    // Gating with rst_ni keeps the readies low while reset is asserted.
    accept_win = rst_ni && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready_i));
    grant0     = accept_win && req0_valid_i && (!req1_valid_i || !prio_q);
    grant1     = accept_win && req1_valid_i && (!req0_valid_i || prio_q);

    case (state_q)
      EXEC: begin
        alu_ctrl_o = ctrl_q;
        alu_a_o    = a_q;
        alu_b_o    = b_q;
        data_d     = alu_result_i;
        taken_d    = alu_branch_i && (ctrl_q[4:3] == 2'b10);
        err_d      = 1'b0;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
      end
      default: ;
    endcase

    if (grant0 || grant1) begin
      sel_ctrl = grant1 ? req1_ctrl_i : req0_ctrl_i;
      ctrl_d   = sel_ctrl;
      a_d      = grant1 ? req1_a_i : req0_a_i;
      b_d      = grant1 ? req1_b_i : req0_b_i;
      id_d     = grant1;
      prio_d   = grant0;
      if (is_legal(sel_ctrl)) begin
        state_d = EXEC;
      end else begin
        state_d = RESP;
        err_d   = 1'b1;
        data_d  = '0;
        taken_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      data_q  <= '0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      data_q  <= data_d;
      taken_q <= taken_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_id_o     = id_q;
  assign rsp_data_o   = data_q;
  assign rsp_taken_o  = taken_q;
  assign rsp_err_o    = err_q;
  assign op_count_o   = cnt_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width.
REQ-002 clk_i  in  1  sole clock, rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 req0_valid_i / req1_valid_i  in  1 each  requester 0/1 has an op pending.
REQ-005 req0_ready_o / req1_ready_o  out  1 each  op accepted this cycle when valid&ready.
REQ-006 req0_ctrl_i / req1_ctrl_i  in  5 each  decoded 5-bit ALU control code.
REQ-007 req0_a_i, req0_b_i, req1_a_i, req1_b_i  in  DATA_W each  operands.
REQ-008 alu_ctrl_o  out  5  control to shared combinational ALU.
REQ-009 alu_a_o, alu_b_o  out  DATA_W each  operands to shared ALU.
REQ-010 alu_result_i  in  DATA_W  ALU result, same-cycle.
REQ-011 alu_branch_i  in  1  ALU branch-compare outcome, same-cycle.
REQ-012 rsp_valid_o  out  1  response pending.
REQ-013 rsp_ready_i  in  1  consumer takes response when valid&ready.
REQ-014 rsp_id_o  out  1  requester index owning the response.
REQ-015 rsp_data_o  out  DATA_W  captured result.
REQ-016 rsp_taken_o  out  1  branch taken; 0 for non-branch codes.
REQ-017 rsp_err_o  out  1  illegal control code.
REQ-018 op_count_o  out  16  completed-response count, saturating.

Function
REQ-019 FSM states IDLE, EXEC, RESP; one request in flight at a time.
REQ-020 Legal codes: 00000-00111, 01000, 01101, 10000, 10001, 10100-10111, 11111; all others illegal.
REQ-021 Branch code: ctrl[4:3]==2'b10.
REQ-022 Accept window: IDLE, or RESP in a cycle where rsp_ready_i=1 (back-to-back).
REQ-023 In accept window, at most one reqN_ready_o asserted, only to a valid requester (ready never high without valid, combinational from valid and state).
REQ-024 Arbitration: round-robin; both valid -> grant the requester not granted last; single valid -> grant it; after reset requester 0 has priority.
REQ-025 On accept: latch ctrl, a, b, id; legal code -> EXEC; illegal code -> RESP directly with rsp_err_o=1, rsp_data_o=0, rsp_taken_o=0.
REQ-026 EXEC lasts exactly one cycle: drive alu_*_o from latched values; at clock edge capture alu_result_i into rsp_data_o, rsp_taken_o = alu_branch_i & branch code, rsp_err_o=0; -> RESP.
REQ-027 Outside EXEC, alu_ctrl_o, alu_a_o, alu_b_o SHALL be 0.
REQ-028 Latency: accept in cycle N -> rsp_valid_o high from cycle N+2 (legal) or N+1 (illegal).
REQ-029 RESP: rsp_valid_o=1, all rsp_* stable until rsp_ready_i=1; then -> EXEC/RESP if new accept same cycle, else IDLE.
REQ-030 rsp_valid_o=0 in IDLE and EXEC.
REQ-031 op_count_o increments on each rsp_valid_o&rsp_ready_i (including errors); holds at 16'hFFFF.
REQ-032 No valid requesters in accept window -> no grant, round-robin pointer unchanged.

Reset
REQ-033 rst_ni low forces immediately: state IDLE, rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, rsp_taken_o=0, rsp_err_o=0, op_count_o=0, alu_*_o=0, ready outputs 0, priority pointer to requester 0.
REQ-034 Reset mid-operation (EXEC or RESP) discards the in-flight op; no response emitted after release.
REQ-035 First accept possible in the first clock edge after rst_ni deasserts.

Verification
REQ-036 Req0 ctrl=00000, a=5, b=7, rsp_ready_i=1 -> ALU sees 00000/5/7 one cycle after accept; rsp_valid_o next cycle, id=0, data=ALU result (12 with reference ALU), err=0, count=1.
REQ-037 Both requesters valid continuously, rsp_ready_i=1 -> grants alternate 0,1,0,1; back-to-back accept on response-take cycles.
REQ-038 Req1 ctrl=10000, a=b=3, alu_branch_i=1 -> rsp_taken_o=1; ctrl=00100 with alu_branch_i=1 -> rsp_taken_o=0.
REQ-039 Req0 ctrl=01001 -> rsp_valid_o at N+1, err=1, data=0, ALU outputs stay 0.
REQ-040 rsp_ready_i held 0 for 5 cycles -> rsp_* stable, both ready outputs 0; then 1 -> IDLE.
REQ-041 rst_ni pulsed low during EXEC -> all outputs reset values immediately; no response after release; op_count_o=0.
